pipeline_stall_controller: RTL and testbench
============================================

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3: cycles needed for the halting ecall to go from EX to WB retirement.
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port hazard_stall, input, 1: load-use or ecall-operand hazard reported for the instruction in ID.
REQ-006 SHALL have port mispredict, input, 1: the branch or jump in EX resolved against the fetched path.
REQ-007 SHALL have port mem_busy, input, 1: data memory multi-cycle access not yet complete.
REQ-008 SHALL have port halt_req, input, 1: ecall with x17==10 resolved in EX.
REQ-009 SHALL have port pc_write, output, 1: PC register write enable.
REQ-010 SHALL have port if_id_write, output, 1: IF/ID write enable.
REQ-011 SHALL have port if_id_flush, output, 1: IF/ID is loaded with a bubble.
REQ-012 SHALL have port id_ex_flush, output, 1: ID/EX is loaded with a bubble (control signals zeroed).
REQ-013 SHALL have port ex_mem_write, output, 1: EX/MEM write enable.
REQ-014 SHALL have port mem_wb_write, output, 1: MEM/WB write enable.
REQ-015 SHALL have port halted, output, 1: registered; the processor has retired the halting ecall.
REQ-016 SHALL have port stall_cycles, output, CNT_W: number of RUN cycles with pc_write=0.
REQ-017 SHALL have port flush_count, output, CNT_W: number of accepted mispredict flushes.

Function
REQ-018 SHALL implement FSM states RUN, DRAIN and HALTED, plus a drain counter sized for DRAIN_CYCLES.
REQ-019 SHALL drive pipeline-control outputs combinationally from state and inputs, with zero-cycle latency.
REQ-020 SHALL, in RUN, apply this priority: mem_busy, then halt_req, then mispredict, then hazard_stall, then normal.
REQ-021 SHALL, in RUN with mem_busy=1, freeze the pipeline: all write enables 0, both flushes 0, state held, other inputs ignored.
REQ-022 SHALL, in RUN with halt_req=1 and mem_busy=0, drive pc_write=0, if_id_flush=1, id_ex_flush=1, ex_mem_write=1, mem_wb_write=1, load the counter with DRAIN_CYCLES and move to DRAIN.
REQ-023 SHALL, in RUN with mispredict=1 (and no higher-priority input), drive pc_write=1, if_id_flush=1, id_ex_flush=1, other write enables 1, and ignore hazard_stall.
REQ-024 SHALL, in RUN with hazard_stall=1 only, drive pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1, mem_wb_write=1.
REQ-025 SHALL, in RUN with no input active, drive all write enables 1 and both flushes 0.
REQ-026 SHALL, in DRAIN, drive pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, and ignore mispredict, hazard_stall and halt_req.
REQ-027 SHALL, in DRAIN with mem_busy=1, drive ex_mem_write=0 and mem_wb_write=0 and hold the counter.
REQ-028 SHALL, in DRAIN with mem_busy=0, drive ex_mem_write=1 and mem_wb_write=1 and decrement the counter.
REQ-029 SHALL move from DRAIN to HALTED on the cycle the counter decrements from 1 to 0.
REQ-030 SHALL set halted to 1 on the edge entering HALTED.
REQ-031 SHALL, in HALTED, drive all write enables 0 and both flushes 0, hold halted=1, and leave HALTED only on reset.
REQ-032 SHALL increment stall_cycles on each RUN cycle with pc_write=0, covering hazard_stall, mem_busy and the halt_req entry cycle.
REQ-033 SHALL increment flush_count on each cycle REQ-023 applies.
REQ-034 SHALL saturate both counters at all-ones and never wrap.
REQ-035 SHALL leave both counters unchanged in DRAIN and HALTED.

Reset
REQ-036 SHALL, when reset=1 at a rising edge, set state=RUN, drain counter=0, halted=0, stall_cycles=0, flush_count=0, regardless of current state.
REQ-037 SHALL, while reset=1, drive all write enables 0, if_id_flush=1 and id_ex_flush=1.
REQ-038 SHALL give reset asserted mid-DRAIN or mid-mem_busy precedence, so the next cycle after deassertion is RUN with no residual stall or drain.

Verification
REQ-039 SHALL be covered by this scenario: hazard_stall=1 for 2 cycles in RUN -> pc_write=0, if_id_write=0, id_ex_flush=1 for both cycles; stall_cycles=2.
REQ-040 SHALL be covered by this scenario: mispredict=1 and hazard_stall=1 in the same cycle -> pc_write=1, if_id_flush=1, id_ex_flush=1; flush_count=1; stall_cycles unchanged.
REQ-041 SHALL be covered by this scenario: mem_busy=1 for 3 cycles with mispredict=1 -> all write enables 0 and flushes 0; flush_count=0; stall_cycles=3.
REQ-042 SHALL be covered by this scenario: halt_req=1 with DRAIN_CYCLES=3 and mem_busy=0 -> DRAIN for 3 cycles, then halted=1 on the 4th edge after the request.
REQ-043 SHALL be covered by this scenario: halt_req=1 followed by mem_busy=1 for 2 cycles during DRAIN -> halted rises 2 cycles later than in REQ-042.
REQ-044 SHALL be covered by this scenario: stall_cycles preloaded near all-ones plus continuous hazard_stall -> the count sticks at all-ones; then reset in HALTED -> halted=0, both counters 0, normal RUN outputs next cycle.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - pipeline stall/flush/halt controller with performance counters
module pipeline_stall_controller #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard_stall,
    input  logic             mispredict,
    input  logic             mem_busy,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int DCW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [DCW-1:0] drain_cnt, drain_cnt_next;
    logic           stall_inc, flush_inc;

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        pc_write       = 1'b0;
        if_id_write    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_write   = 1'b0;
        mem_wb_write   = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        if (reset) begin
            // Bubbles into the front of the pipe while reset is held.
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            state_next     = RUN;
            drain_cnt_next = '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        stall_inc = 1'b1;
                    end else if (halt_req) begin
                        // Older instructions keep retiring; younger ones are squashed.
                        if_id_write    = 1'b1;
                        if_id_flush    = 1'b1;
                        id_ex_flush    = 1'b1;
                        ex_mem_write   = 1'b1;
                        mem_wb_write   = 1'b1;
                        stall_inc      = 1'b1;
                        drain_cnt_next = DCW'(DRAIN_CYCLES);
                        state_next     = DRAIN;
                    end else if (mispredict) begin
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                        flush_inc    = 1'b1;
                    end else if (hazard_stall) begin
                        id_ex_flush  = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                        stall_inc    = 1'b1;
                    end else begin
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                    end
                end
                DRAIN: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (!mem_busy) begin
                        ex_mem_write   = 1'b1;
                        mem_wb_write   = 1'b1;
                        drain_cnt_next = drain_cnt - DCW'(1);
                        if (drain_cnt == DCW'(1)) begin
                            state_next = HALTED;
                        end
                    end
                end
                HALTED: begin
                    state_next = HALTED;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            drain_cnt    <= '0;
            halted       <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            halted    <= (state_next == HALTED);
            if (stall_inc && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_inc && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed self-checking bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

    localparam int CNT_W = 4;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write}
    localparam logic [5:0] C_NORMAL = 6'b110011;
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_HALTIN = 6'b011111;
    localparam logic [5:0] C_MISP   = 6'b111111;
    localparam logic [5:0] C_HAZ    = 6'b000111;
    localparam logic [5:0] C_DRAIN  = 6'b001111;
    localparam logic [5:0] C_DRBUSY = 6'b001100;
    localparam logic [5:0] C_HALTED = 6'b000000;
    localparam logic [5:0] C_RESET  = 6'b001100;

    logic             clk = 1'b0;
    logic             reset;
    logic             hazard_stall, mispredict, mem_busy, halt_req;
    logic             pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic             ex_mem_write, mem_wb_write, halted;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [5:0]       ctl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write};

    pipeline_stall_controller #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .hazard_stall (hazard_stall),
        .mispredict   (mispredict),
        .mem_busy     (mem_busy),
        .halt_req     (halt_req),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_write (ex_mem_write),
        .mem_wb_write (mem_wb_write),
        .halted       (halted),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs at negedge, check combinational controls, then advance one edge.
    task automatic cyc(input logic rst, input logic hz, input logic mp, input logic mb,
                       input logic hr, input logic [5:0] exp_ctl, input string tag);
        @(negedge clk);
        reset = rst; hazard_stall = hz; mispredict = mp; mem_busy = mb; halt_req = hr;
        #1;
        chk(tag, 32'(ctl), 32'(exp_ctl));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic h, input int sc, input int fc);
        chk({tag, "_halted"}, 32'(halted), 32'(h));
        chk({tag, "_stall"},  32'(stall_cycles), 32'(sc));
        chk({tag, "_flush"},  32'(flush_count), 32'(fc));
    endtask

    initial begin
        reset = 1'b1; hazard_stall = 1'b0; mispredict = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;
        cyc(1, 0, 0, 0, 0, C_RESET, "reset_ctl0");
        cyc(1, 1, 1, 1, 1, C_RESET, "reset_ctl1");
        chk_regs("reset", 0, 0, 0);

        // Two hazard stalls
        cyc(0, 1, 0, 0, 0, C_HAZ, "haz1");
        cyc(0, 1, 0, 0, 0, C_HAZ, "haz2");
        chk_regs("haz", 0, 2, 0);

        // Mispredict wins over hazard
        cyc(0, 1, 1, 0, 0, C_MISP, "misp_haz");
        chk_regs("misp", 0, 2, 1);

        // mem_busy freezes, mispredict ignored
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, C_FREEZE, "busy_misp");
        chk_regs("busy", 0, 5, 1);
        cyc(0, 0, 0, 0, 0, C_NORMAL, "normal");
        chk_regs("normal", 0, 5, 1);

        // mem_busy outranks halt_req
        cyc(0, 0, 0, 1, 1, C_FREEZE, "busy_halt");
        chk_regs("busy_halt", 0, 6, 1);

        // Halt with no memory stalls: halted on 4th edge
        cyc(0, 0, 0, 0, 1, C_HALTIN, "halt_entry");
        chk_regs("halt_e1", 0, 7, 1);
        cyc(0, 1, 1, 0, 1, C_DRAIN, "drain1");
        chk("drain_e2_halted", 32'(halted), 32'd0);
        cyc(0, 0, 0, 0, 0, C_DRAIN, "drain2");
        chk("drain_e3_halted", 32'(halted), 32'd0);
        cyc(0, 0, 0, 0, 0, C_DRAIN, "drain3");
        chk_regs("halt_e4", 1, 7, 1);
        cyc(0, 1, 1, 0, 1, C_HALTED, "halted_ctl");
        chk_regs("halted_hold", 1, 7, 1);

        // Reset out of HALTED
        cyc(1, 0, 0, 0, 0, C_RESET, "reset_halted");
        chk_regs("post_reset", 0, 0, 0);

        // Halt with two memory-busy cycles in DRAIN
        cyc(0, 0, 0, 0, 1, C_HALTIN, "halt2_entry");
        cyc(0, 0, 0, 1, 0, C_DRBUSY, "drain_busy1");
        cyc(0, 0, 1, 1, 0, C_DRBUSY, "drain_busy2");
        cyc(0, 0, 0, 0, 0, C_DRAIN, "drain2_1");
        cyc(0, 0, 0, 0, 0, C_DRAIN, "drain2_2");
        chk("halt2_e5_halted", 32'(halted), 32'd0);
        cyc(0, 0, 0, 0, 0, C_DRAIN, "drain2_3");
        chk_regs("halt2_e6", 1, 1, 0);

        // Reset mid-DRAIN leaves no residual drain
        cyc(1, 0, 0, 0, 0, C_RESET, "reset_a");
        cyc(0, 0, 0, 0, 1, C_HALTIN, "halt3_entry");
        cyc(0, 0, 0, 1, 0, C_DRBUSY, "drain3_busy");
        cyc(1, 0, 0, 1, 0, C_RESET, "reset_mid_drain");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, C_NORMAL, "after_drain_reset");
        chk_regs("after_drain_reset", 0, 0, 0);

        // Reset mid-mem_busy
        cyc(0, 0, 0, 1, 0, C_FREEZE, "busy_pre_reset");
        cyc(1, 0, 0, 1, 0, C_RESET, "reset_mid_busy");
        cyc(0, 0, 0, 0, 0, C_NORMAL, "after_busy_reset");
        chk_regs("after_busy_reset", 0, 0, 0);

        // Saturation of stall_cycles at all-ones
        for (int i = 0; i < 14; i++) cyc(0, 1, 0, 0, 0, C_HAZ, "sat_haz");
        chk("stall_14", 32'(stall_cycles), 32'd14);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0, C_HAZ, "sat_haz");
        chk("stall_sat", 32'(stall_cycles), 32'd15);

        // Saturation of flush_count
        for (int i = 0; i < 17; i++) cyc(0, 0, 1, 0, 0, C_MISP, "sat_misp");
        chk("flush_sat", 32'(flush_count), 32'd15);

        // Halt from saturated state, then reset in HALTED
        cyc(0, 0, 0, 0, 1, C_HALTIN, "halt4_entry");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, C_DRAIN, "drain4");
        chk_regs("halt4", 1, 15, 15);
        cyc(1, 0, 0, 0, 0, C_RESET, "reset_halted2");
        chk_regs("reset_halted2", 0, 0, 0);
        cyc(0, 0, 0, 0, 0, C_NORMAL, "normal_after_reset");
        chk_regs("normal_after_reset", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
